// File: rtl/video_frame_read_ctrl_if.sv
// DDR3 read-burst request channel between the frame read controller (master)
// and the memory arbiter (slave).
interface video_frame_read_ctrl_if #(
    parameter int ADDR_W = 28
) ();
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_len;
    logic              rd_ack;
    logic              rd_done;

    modport master (
        output rd_req,
        output rd_addr,
        output rd_len,
        input  rd_ack,
        input  rd_done
    );

    modport slave (
        input  rd_req,
        input  rd_addr,
        input  rd_len,
        output rd_ack,
        output rd_done
    );
endinterface

// File: rtl/video_frame_read_ctrl.sv
// Frame-buffer read scheduler: on each vsync edge flushes the output FIFO and fetches
// one frame as fixed-length bursts, one outstanding at a time, while FIFO space allows.
module video_frame_read_ctrl #(
    parameter int          WORDS_PER_LINE = 160,
    parameter int          V_ACTIVE       = 720,
    parameter int          BURST_WORDS    = 32,
    parameter int          LINE_STRIDE    = 160,
    parameter logic [31:0] FRAME_STRIDE   = 32'h40000,
    parameter int          ADDR_W         = 28,
    parameter int          FIFO_DEPTH     = 512,
    parameter int          CNT_W          = 10,
    parameter logic        VS_POL         = 1'b1,
    parameter int          FLUSH_CYCLES   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_vs,
    input  logic                 i_de,
    input  logic [1:0]           i_buf_sel,
    input  logic [CNT_W-1:0]     i_fifo_wr_count,
    input  logic                 i_fifo_empty,
    video_frame_read_ctrl_if.master rd_bus,
    output logic                 o_fifo_flush,
    output logic                 o_frame_busy,
    output logic                 o_underrun
);

    localparam int BURSTS_PER_LINE = WORDS_PER_LINE / BURST_WORDS;
    localparam int LINE_W          = $clog2(V_ACTIVE + 1);
    localparam int BURST_W         = $clog2(BURSTS_PER_LINE + 1);
    localparam int FLUSH_W         = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_CHECK,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_vs_q;
    logic [1:0]          r_buf_sel;
    logic [FLUSH_W-1:0]  r_flush_cnt;
    logic [ADDR_W-1:0]   r_base;
    logic [LINE_W-1:0]   r_line;
    logic [BURST_W-1:0]  r_burst;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_pend;
    logic                r_underrun;

    logic                w_vs_edge;
    logic                w_space_ok;
    logic                w_enter_flush;
    logic                w_in_frame;
    logic [ADDR_W-1:0]   w_addr_calc;

    assign w_vs_edge   = (r_vs_q != VS_POL) && (i_vs == VS_POL);
    assign w_space_ok  = (32'(i_fifo_wr_count) + 32'(BURST_WORDS)) <= 32'(FIFO_DEPTH);
    assign w_in_frame  = (r_state == S_CHECK) || (r_state == S_REQ) ||
                         (r_state == S_WAIT)  || (r_state == S_DONE);
    // Wraps modulo 2^ADDR_W by construction of the operand widths.
    assign w_addr_calc = r_base
                       + ADDR_W'(r_line)  * ADDR_W'(LINE_STRIDE)
                       + ADDR_W'(r_burst) * ADDR_W'(BURST_WORDS);

    always_comb begin
        w_state_next  = r_state;
        w_enter_flush = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_vs_edge) w_state_next = S_FLUSH;
            end
            S_FLUSH: begin
                if (w_vs_edge)
                    w_state_next = S_FLUSH;
                else if (r_flush_cnt == FLUSH_W'(FLUSH_CYCLES - 1))
                    w_state_next = S_CHECK;
            end
            S_CHECK: begin
                if (w_vs_edge)
                    w_state_next = S_FLUSH;
                else if (r_line == LINE_W'(V_ACTIVE))
                    w_state_next = S_DONE;
                else if (w_space_ok)
                    w_state_next = S_REQ;
            end
            S_REQ: begin
                // An accepted burst must complete, so ack beats a coincident vsync edge.
                if (rd_bus.rd_ack)
                    w_state_next = S_WAIT;
                else if (w_vs_edge)
                    w_state_next = S_FLUSH;
            end
            S_WAIT: begin
                if (rd_bus.rd_done)
                    w_state_next = (r_pend || w_vs_edge) ? S_FLUSH : S_CHECK;
            end
            default: w_state_next = S_IDLE;
        endcase
        w_enter_flush = (w_state_next == S_FLUSH) && ((r_state != S_FLUSH) || w_vs_edge);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_vs_q      <= VS_POL;
            r_buf_sel   <= '0;
            r_flush_cnt <= '0;
            r_base      <= '0;
            r_line      <= '0;
            r_burst     <= '0;
            r_addr      <= '0;
            r_pend      <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_vs_q  <= i_vs;

            if (w_vs_edge) r_buf_sel <= i_buf_sel;

            if (w_enter_flush)
                r_flush_cnt <= '0;
            else if (r_state == S_FLUSH)
                r_flush_cnt <= r_flush_cnt + FLUSH_W'(1);

            if (r_state == S_FLUSH) begin
                r_base  <= ADDR_W'(r_buf_sel) * ADDR_W'(FRAME_STRIDE);
                r_line  <= '0;
                r_burst <= '0;
            end else if (r_state == S_WAIT && rd_bus.rd_done) begin
                if (r_burst == BURST_W'(BURSTS_PER_LINE - 1)) begin
                    r_burst <= '0;
                    r_line  <= r_line + LINE_W'(1);
                end else begin
                    r_burst <= r_burst + BURST_W'(1);
                end
            end

            if (r_state == S_CHECK && w_state_next == S_REQ) r_addr <= w_addr_calc;

            // Pending restart is remembered only while a burst is in flight.
            if (r_state == S_FLUSH)
                r_pend <= 1'b0;
            else if (w_vs_edge && ((r_state == S_WAIT) || (r_state == S_REQ && rd_bus.rd_ack)))
                r_pend <= 1'b1;

            if (r_state == S_FLUSH)
                r_underrun <= 1'b0;
            else if (w_in_frame && i_de && i_fifo_empty)
                r_underrun <= 1'b1;
        end
    end

    assign rd_bus.rd_req  = (r_state == S_REQ);
    assign rd_bus.rd_addr = r_addr;
    assign rd_bus.rd_len  = 8'(BURST_WORDS);
    assign o_fifo_flush   = (r_state == S_FLUSH);
    assign o_frame_busy   = (r_state == S_FLUSH) || (r_state == S_CHECK) ||
                            (r_state == S_REQ)   || (r_state == S_WAIT);
    assign o_underrun     = r_underrun;

endmodule
